// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder: the only arithmetic in the serial adder.
// Latency: combinational.
// Backpressure: none.
module serial_adder_ctrl_fa_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell walks the operands LSB first.
// Latency: start accepted at E0, done high in the cycle after edge E0+N.
// Backpressure: start is only sampled in IDLE; pulses while busy or done are dropped.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state;
    state_t         state_nxt;
    logic           load;
    logic           step;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   sum_sr;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           cell_s;
    logic           cell_c;

    serial_adder_ctrl_fa_cell u_fa_cell (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .z (carry),
        .s (cell_s),
        .c (cell_c)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // sum_sr is not cleared on load: the previous result stays visible until bits overwrite it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= (sum_sr >> 1) | (N'(cell_s) << (N - 1));
            carry  <= cell_c;
            cnt    <= cnt + 1'b1;
        end
    end

    assign sum  = sum_sr;
    assign cout = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with an N=8 and an N=1 instance.
module tb_serial_adder_ctrl;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int errors = 0;
    int checks = 0;
    int dcount;

    serial_adder_ctrl #(.N(8)) dut8 (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    serial_adder_ctrl #(.N(1)) dut1 (
        .clock  (clock),
        .resetn (resetn),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .cin    (cin1),
        .busy   (busy1),
        .done   (done1),
        .sum    (sum1),
        .cout   (cout1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One full operation on the N=8 instance, starting from IDLE.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic [7:0] es, input logic ec, input string tag);
        a = av; b = bv; cin = ci; start = 1'b1;
        tick;
        start = 1'b0; a = 8'hxx; b = 8'hxx; cin = 1'bx;
        check({tag, "_busy_after_e0"}, 32'(busy), 32'd1);
        dcount = 0;
        for (int i = 1; i < 8; i++) begin
            tick;
            if (done) dcount++;
        end
        check({tag, "_busy_e0+7"}, 32'(busy), 32'd1);
        tick;
        if (done) dcount++;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_done_count"}, 32'(dcount), 32'd1);
        tick;
        check({tag, "_done_falls"}, 32'(done), 32'd0);
        check({tag, "_sum_held"}, 32'(sum), 32'(es));
        check({tag, "_cout_held"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        // Release with start already high: the deassertion must not count as a start.
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("no_start_on_release", 32'(busy), 32'd0);
        start = 1'b0;
        tick;
        check("idle_after_release", 32'(busy), 32'd0);

        do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "op_5a_3c");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "op_ff_01");
        do_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "op_ff_00_c1");

        // start held high through RUN with operands changing after acceptance
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick;
        a = 8'h01; b = 8'h01;
        dcount = 0;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (done) dcount++;
        end
        check("held_done", 32'(done), 32'd1);
        check("held_sum", 32'(sum), 32'h46);
        check("held_done_count", 32'(dcount), 32'd1);
        tick;
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_done", 32'(done), 32'd0);
        tick;
        check("held_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (8) tick;
        check("held2_done", 32'(done), 32'd1);
        check("held2_sum", 32'(sum), 32'h02);
        check("held2_cout", 32'(cout), 32'd0);
        tick;

        // reset mid-RUN after four bits of 0xAA + 0x55
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_partial", 32'(sum), 32'hF0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_sum",  32'(sum),  32'd0);
        check("async_cout", 32'(cout), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        tick;
        check("post_rst_idle", 32'(busy), 32'd0);
        do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "after_rst");

        // back-to-back at the earliest legal spacing
        do_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, "b2b_first");
        do_op(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, "b2b_second");

        // N=1 instance
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        check("n1_busy", 32'(busy1), 32'd1);
        check("n1_early_done", 32'(done1), 32'd0);
        tick;
        check("n1_done", 32'(done1), 32'd1);
        check("n1_busy_in_done", 32'(busy1), 32'd0);
        check("n1_sum", 32'(sum1), 32'd1);
        check("n1_cout", 32'(cout1), 32'd1);
        tick;
        check("n1_done_falls", 32'(done1), 32'd0);
        a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        tick;
        check("n1b_done", 32'(done1), 32'd1);
        check("n1b_sum", 32'(sum1), 32'd1);
        check("n1b_cout", 32'(cout1), 32'd0);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
